// File: rtl/p_bool_pack.sv
// Binarizing packer: thresholds a stream of signed results to single bits and
// packs OUT of them per output vector. Two-deep buffering (pack register plus
// output register) lets one vector wait while the previous one is being consumed.
module p_bool_pack #(
  parameter int unsigned OUT  = 8,
  parameter int unsigned PREC = 16,
  parameter logic        PAD  = 1'b0,
  localparam int unsigned IW  = $clog2(OUT),
  localparam int unsigned CW  = $clog2(OUT + 1)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PREC-1:0] in_data,
  input  logic            in_last,
  input  logic [PREC-1:0] thresh,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OUT-1:0]  out_data,
  output logic [CW-1:0]   out_cnt,
  output logic            out_last
);

  // Pack stage
  logic [IW-1:0]  idx_q, idx_d;
  logic [OUT-1:0] pack_q, pack_d;
  logic [CW-1:0]  pack_cnt_q, pack_cnt_d;
  logic           pack_last_q, pack_last_d;
  logic           pack_full_q, pack_full_d;

  // Output stage
  logic [OUT-1:0] out_data_q, out_data_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic           out_last_q, out_last_d;
  logic           out_valid_q, out_valid_d;

  logic           bit_v;
  logic [OUT-1:0] vec;
  logic [CW-1:0]  cnt_new;
  logic           accept, complete, drain, out_free;

  // Candidate vector: earlier bits from the pack register, the new bit at idx,
  // PAD above it. Also serves as the updated partial vector while filling.
  always_comb begin
    bit_v   = $signed(in_data) >= $signed(thresh);
    cnt_new = CW'(idx_q) + CW'(1);
    vec     = '0;
    for (int i = 0; i < int'(OUT); i++) begin
      if (i < int'(idx_q)) begin
        vec[i] = pack_q[i];
      end else if (i == int'(idx_q)) begin
        vec[i] = bit_v;
      end else begin
        vec[i] = PAD;
      end
    end
  end

  // Next-state for both stages
  always_comb begin
    accept   = in_valid && !pack_full_q;
    complete = accept && ((idx_q == IW'(OUT - 1)) || in_last);
    drain    = out_valid_q && out_ready;
    out_free = !out_valid_q || drain;

    idx_d       = idx_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    pack_last_d = pack_last_q;
    pack_full_d = pack_full_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      pack_d = vec;
      idx_d  = complete ? '0 : idx_q + IW'(1);
      if (complete) begin
        pack_cnt_d  = cnt_new;
        pack_last_d = in_last;
      end
    end

    // A held vector has priority; no accept can complete while it is held.
    if (pack_full_q && drain) begin
      out_data_d  = pack_q;
      out_cnt_d   = pack_cnt_q;
      out_last_d  = pack_last_q;
      out_valid_d = 1'b1;
      pack_full_d = 1'b0;
    end else if (complete && out_free) begin
      out_data_d  = vec;
      out_cnt_d   = cnt_new;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
    end else begin
      if (complete) begin
        pack_full_d = 1'b1;
      end
      if (drain) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with asynchronous reset; a partial vector is dropped
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      idx_q       <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      pack_last_q <= 1'b0;
      pack_full_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      pack_last_q <= pack_last_d;
      pack_full_q <= pack_full_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = !pack_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_p_bool_pack.sv
// Directed bench for p_bool_pack: table of packed vectors plus hand sequences
// for backpressure, asynchronous reset and drain/complete collision.
module tb_p_bool_pack;

  localparam int unsigned OUT  = 8;
  localparam int unsigned PREC = 16;
  localparam int unsigned CW   = $clog2(OUT + 1);

  logic            clk = 1'b0;
  logic            reset_;
  logic            in_valid, in_last, out_ready;
  logic [PREC-1:0] in_data, thresh;
  logic            in_ready, out_valid, out_last;
  logic [OUT-1:0]  out_data;
  logic [CW-1:0]   out_cnt;
  logic            p_in_ready, p_out_valid, p_out_last;
  logic [OUT-1:0]  p_out_data;
  logic [CW-1:0]   p_out_cnt;

  int checks = 0;
  int failures = 0;

  p_bool_pack #(.OUT(OUT), .PREC(PREC), .PAD(1'b0)) u_dut (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .thresh(thresh), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt), .out_last(out_last)
  );

  p_bool_pack #(.OUT(OUT), .PREC(PREC), .PAD(1'b1)) u_dut_pad (
    .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_data(in_data), .in_last(in_last), .thresh(thresh), .out_valid(p_out_valid),
    .out_ready(out_ready), .out_data(p_out_data), .out_cnt(p_out_cnt), .out_last(p_out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [7:0][15:0] d;
    logic [15:0]      th;
    logic [7:0]       exp_d;
    logic [7:0]       exp_pad;
    int               exp_cnt;
    logic             exp_last;
  } vec_t;

  vec_t recs[8];

  function automatic vec_t mk(int n, int th, int e0, int e1, int e2, int e3, int e4, int e5,
                              int e6, int e7, logic [7:0] ed, logic [7:0] ep, int ec,
                              logic el);
    vec_t r;
    r.n = n;
    r.th = 16'(th);
    r.d[0] = 16'(e0); r.d[1] = 16'(e1); r.d[2] = 16'(e2); r.d[3] = 16'(e3);
    r.d[4] = 16'(e4); r.d[5] = 16'(e5); r.d[6] = 16'(e6); r.d[7] = 16'(e7);
    r.exp_d = ed;
    r.exp_pad = ep;
    r.exp_cnt = ec;
    r.exp_last = el;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Feed one record with out_ready=1, check the emitted vector and the drop after drain
  task automatic apply_rec(input int r);
    for (int k = 0; k < recs[r].n; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = recs[r].d[k];
      thresh   = recs[r].th;
      in_last  = recs[r].exp_last && (k == recs[r].n - 1);
      chk($sformatf("rec%0d in_ready e%0d", r, k), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk($sformatf("rec%0d out_valid", r), 32'(out_valid), 32'd1);
    chk($sformatf("rec%0d out_data", r), 32'(out_data), 32'(recs[r].exp_d));
    chk($sformatf("rec%0d out_cnt", r), 32'(out_cnt), 32'(recs[r].exp_cnt));
    chk($sformatf("rec%0d out_last", r), 32'(out_last), 32'(recs[r].exp_last));
    chk($sformatf("rec%0d pad out_data", r), 32'(p_out_data), 32'(recs[r].exp_pad));
    @(negedge clk);
    chk($sformatf("rec%0d out_valid drop", r), 32'(out_valid), 32'd0);
  endtask

  task automatic send(input int v, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(v);
    in_last  = last;
  endtask

  initial begin
    recs[0] = mk(8, 0, 3, -1, 0, -5, 7, -2, 1, -8, 8'h55, 8'h55, 8, 1'b0);
    recs[1] = mk(3, 0, 1, 1, -1, 0, 0, 0, 0, 0, 8'h03, 8'hFB, 3, 1'b1);
    recs[2] = mk(2, 'h8000, 'h8000, 'h7FFF, 0, 0, 0, 0, 0, 0, 8'h03, 8'hFF, 2, 1'b1);
    recs[3] = mk(2, 'h7FFF, 'h8000, 'h7FFF, 0, 0, 0, 0, 0, 0, 8'h02, 8'hFE, 2, 1'b1);
    recs[4] = mk(2, -3, -3, -4, 0, 0, 0, 0, 0, 0, 8'h01, 8'hFD, 2, 1'b1);
    recs[5] = mk(8, 10, 20, 0, 20, 0, 0, 0, 0, 20, 8'h85, 8'h85, 8, 1'b1);
    recs[6] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h01, 8'hFF, 1, 1'b1);
    recs[7] = mk(8, 0, 1, -1, -1, -1, -1, -1, -1, -1, 8'h01, 8'h01, 8, 1'b0);

    reset_ = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_data = '0; thresh = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_cnt", 32'(out_cnt), 32'd0);
    chk("reset out_last", 32'(out_last), 32'd0);
    reset_ = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);

    for (int r = 0; r < 8; r++) apply_rec(r);

    // Backpressure: two vectors absorbed, then stall; 17th element waits
    out_ready = 1'b0;
    thresh = 16'd0;
    for (int k = 0; k < 16; k++) begin
      send(5, 1'b0);
      chk($sformatf("bp in_ready e%0d", k), 32'(in_ready), 32'd1);
    end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp stall in_ready c%0d", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp hold out_valid c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold out_data c%0d", c), 32'(out_data), 32'hFF);
      chk($sformatf("bp hold out_cnt c%0d", c), 32'(out_cnt), 32'd8);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp second out_valid", 32'(out_valid), 32'd1);
    chk("bp second out_data", 32'(out_data), 32'hFF);
    chk("bp second out_last", 32'(out_last), 32'd0);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp drained out_valid", 32'(out_valid), 32'd0);
    in_data = 16'(-5);
    in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp 17th out_valid", 32'(out_valid), 32'd1);
    chk("bp 17th out_data", 32'(out_data), 32'h01);
    chk("bp 17th out_cnt", 32'(out_cnt), 32'd2);
    chk("bp 17th out_last", 32'(out_last), 32'd1);
    @(negedge clk);

    // Asynchronous reset with a full vector pending and a partial one in flight
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) send(5, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst pre out_valid", 32'(out_valid), 32'd1);
    #2;
    reset_ = 1'b0;
    #1;
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async out_data", 32'(out_data), 32'd0);
    chk("rst async out_cnt", 32'(out_cnt), 32'd0);
    #4;
    reset_ = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    apply_rec(7);

    // Drain of vector A coincides with completion of vector B
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(5, 1'b0);
    for (int k = 0; k < 7; k++) begin
      send(-5, 1'b0);
      chk($sformatf("col in_ready e%0d", k), 32'(in_ready), 32'd1);
    end
    send(5, 1'b0);
    chk("col in_ready e7", 32'(in_ready), 32'd1);
    chk("col A out_data", 32'(out_data), 32'hFF);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("col B out_valid", 32'(out_valid), 32'd1);
    chk("col B out_data", 32'(out_data), 32'h80);
    chk("col B out_cnt", 32'(out_cnt), 32'd8);
    chk("col in_ready after", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("col drained", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
